weight_bram_loader: RTL and testbench

Streaming write-side controller for the weight BRAM array. It accepts a valid/ready stream of weight words, distributes them across the NUM_BRAMS weight banks, then hands the filled address window to the downstream wavefront read counter. It holds off until that counter reports done. It sits directly upstream of the weight read counter and shares the BRAM bank/address geometry with it.

---
 rtl/weight_bram_loader_pkg.sv | 22 ++
 rtl/weight_bram_loader_if.sv | 13 +
 rtl/weight_wr_addr_gen.sv | 66 ++++++
 rtl/weight_bram_loader.sv | 146 ++++++++++++++
 tb/tb_weight_bram_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_bram_loader_pkg.sv
// Shared geometry and state encoding for the weight BRAM loader and its read counter.
package weight_bram_loader_pkg;

    localparam int unsigned NumBramsDef  = 16;
    localparam int unsigned AddrWidthDef = 9;
    localparam int unsigned DataWidthDef = 16;
    localparam int unsigned BankIdxWDef  = $clog2(NumBramsDef);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StKick   = 3'd2,
        StWaitRd = 3'd3,
        StDone   = 3'd4
    } state_e;

    // Keeps a bank index at least one bit wide even for a single-bank build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_bram_loader_if.sv
// Valid/ready weight-word stream feeding the loader.
interface weight_bram_loader_if import weight_bram_loader_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DataWidthDef
) ();

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/weight_wr_addr_gen.sv
// Bank/row counter pair: turns accepted beats into a one-hot bank write at base + row.
module weight_wr_addr_gen import weight_bram_loader_pkg::*; #(
    parameter int unsigned NUM_BRAMS  = NumBramsDef,
    parameter int unsigned ADDR_WIDTH = AddrWidthDef
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   num_rows_i,
    output logic [NUM_BRAMS-1:0]  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam int unsigned     BankW   = idx_width(NUM_BRAMS);
    localparam logic [BankW-1:0] BankMax = BankW'(NUM_BRAMS - 1);

    logic [BankW-1:0]      bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [NUM_BRAMS-1:0]  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  bank_wrap;

    always_comb begin
        bank_wrap = (bank_q == BankMax);
        // Last beat: final bank of the final row.
        last_o    = bank_wrap && ({1'b0, row_q} == (num_rows_i - (ADDR_WIDTH + 1)'(1)));
        bank_d    = bank_q;
        row_d     = row_q;
        we_d      = '0;
        addr_d    = addr_q;
        if (clear_i) begin
            bank_d = '0;
            row_d  = '0;
        end else if (accept_i) begin
            we_d   = NUM_BRAMS'(1) << bank_q;
            addr_d = base_i + row_q;
            if (bank_wrap) begin
                bank_d = '0;
                row_d  = row_q + ADDR_WIDTH'(1);
            end else begin
                bank_d = bank_q + BankW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
            row_q  <= '0;
            we_q   <= '0;
            addr_q <= '0;
        end else begin
            bank_q <= bank_d;
            row_q  <= row_d;
            we_q   <= we_d;
            addr_q <= addr_d;
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/weight_bram_loader.sv
// Write-side weight BRAM loader: fills the bank window, kicks the read counter, waits for done.
module weight_bram_loader import weight_bram_loader_pkg::*; #(
    parameter int unsigned NUM_BRAMS  = NumBramsDef,
    parameter int unsigned ADDR_WIDTH = AddrWidthDef,
    parameter int unsigned DATA_WIDTH = DataWidthDef
) (
    input  logic                            clk_i,
    input  logic                            rst_n,
    input  logic                            load_start_i,
    input  logic [ADDR_WIDTH-1:0]           base_addr_i,
    input  logic [ADDR_WIDTH:0]             num_rows_i,
    weight_bram_loader_if.slave             s_if,
    output logic [NUM_BRAMS-1:0]            w_we_o,
    output logic [ADDR_WIDTH-1:0]           w_addr_wr_o,
    output logic [NUM_BRAMS*DATA_WIDTH-1:0] w_din_flat_o,
    output logic                            rd_start_o,
    output logic [ADDR_WIDTH-1:0]           rd_addr_start_o,
    output logic [ADDR_WIDTH-1:0]           rd_addr_end_o,
    input  logic                            rd_done_i,
    output logic                            busy_o,
    output logic                            load_done_o,
    output logic                            cfg_err_o
);

    localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [ADDR_WIDTH:0]             nrows_q, nrows_d;
    logic [ADDR_WIDTH-1:0]           rd_as_q, rd_as_d;
    logic [ADDR_WIDTH-1:0]           rd_ae_q, rd_ae_d;
    logic [NUM_BRAMS*DATA_WIDTH-1:0] w_din_q, w_din_d;
    logic                            s_ready_q, s_ready_d;
    logic                            rd_start_q, rd_start_d;
    logic                            busy_q, busy_d;
    logic                            load_done_q, load_done_d;
    logic                            cfg_err_q, cfg_err_d;

    logic                  accept, last_beat, clear, cfg_ok;
    logic [ADDR_WIDTH:0]   span_end;

    assign accept = s_if.s_valid && s_ready_q;

    weight_wr_addr_gen #(
        .NUM_BRAMS  (NUM_BRAMS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .accept_i   (accept),
        .base_i     (base_q),
        .num_rows_i (nrows_q),
        .we_o       (w_we_o),
        .addr_o     (w_addr_wr_o),
        .last_o     (last_beat)
    );

    always_comb begin
        // Window must fit in the bank; num_rows is bounded first so the sum cannot wrap.
        span_end    = {1'b0, base_addr_i} + num_rows_i;
        cfg_ok      = (num_rows_i != '0) && (num_rows_i <= Depth) && (span_end <= Depth);
        state_d     = state_q;
        base_d      = base_q;
        nrows_d     = nrows_q;
        rd_as_d     = rd_as_q;
        rd_ae_d     = rd_ae_q;
        clear       = 1'b0;
        rd_start_d  = 1'b0;
        load_done_d = 1'b0;
        cfg_err_d   = 1'b0;
        w_din_d     = accept ? {NUM_BRAMS{s_if.s_data}} : w_din_q;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    if (cfg_ok) begin
                        state_d = StLoad;
                        base_d  = base_addr_i;
                        nrows_d = num_rows_i;
                        clear   = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                // rd_start lands in the same cycle as the final write.
                if (accept && last_beat) begin
                    state_d    = StKick;
                    rd_start_d = 1'b1;
                    rd_as_d    = base_q;
                    rd_ae_d    = base_q + nrows_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                end
            end
            StKick: state_d = StWaitRd;
            StWaitRd: begin
                if (rd_done_i) begin
                    state_d     = StDone;
                    load_done_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        s_ready_d = (state_d == StLoad);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            nrows_q     <= '0;
            rd_as_q     <= '0;
            rd_ae_q     <= '0;
            w_din_q     <= '0;
            s_ready_q   <= 1'b0;
            rd_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nrows_q     <= nrows_d;
            rd_as_q     <= rd_as_d;
            rd_ae_q     <= rd_ae_d;
            w_din_q     <= w_din_d;
            s_ready_q   <= s_ready_d;
            rd_start_q  <= rd_start_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign s_if.s_ready    = s_ready_q;
    assign w_din_flat_o    = w_din_q;
    assign rd_start_o      = rd_start_q;
    assign rd_addr_start_o = rd_as_q;
    assign rd_addr_end_o   = rd_ae_q;
    assign busy_o          = busy_q;
    assign load_done_o     = load_done_q;
    assign cfg_err_o       = cfg_err_q;

endmodule

// File: tb/tb_weight_bram_loader.sv
// Directed bench for weight_bram_loader: loads, stalls, config rejects, handshake, reset.
module tb_weight_bram_loader;

    localparam int unsigned NB = 16;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              rd_done = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       num_rows = '0;
    logic [NB-1:0]     w_we;
    logic [AW-1:0]     w_addr_wr;
    logic [NB*DW-1:0]  w_din_flat;
    logic              rd_start;
    logic [AW-1:0]     rd_addr_start;
    logic [AW-1:0]     rd_addr_end;
    logic              busy;
    logic              load_done;
    logic              cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    weight_bram_loader_if #(.DATA_WIDTH(DW)) s_if ();

    weight_bram_loader #(
        .NUM_BRAMS  (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i           (clk),
        .rst_n           (rst_n),
        .load_start_i    (load_start),
        .base_addr_i     (base_addr),
        .num_rows_i      (num_rows),
        .s_if            (s_if),
        .w_we_o          (w_we),
        .w_addr_wr_o     (w_addr_wr),
        .w_din_flat_o    (w_din_flat),
        .rd_start_o      (rd_start),
        .rd_addr_start_o (rd_addr_start),
        .rd_addr_end_o   (rd_addr_end),
        .rd_done_i       (rd_done),
        .busy_o          (busy),
        .load_done_o     (load_done),
        .cfg_err_o       (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " w_we"}, 256'(w_we), 256'(0));
        chk({tag, " w_addr_wr"}, 256'(w_addr_wr), 256'(0));
        chk({tag, " w_din_flat"}, 256'(w_din_flat), 256'(0));
        chk({tag, " s_ready"}, 256'(s_if.s_ready), 256'(0));
        chk({tag, " rd_start"}, 256'(rd_start), 256'(0));
        chk({tag, " rd_addr_start"}, 256'(rd_addr_start), 256'(0));
        chk({tag, " rd_addr_end"}, 256'(rd_addr_end), 256'(0));
        chk({tag, " busy"}, 256'(busy), 256'(0));
        chk({tag, " load_done"}, 256'(load_done), 256'(0));
        chk({tag, " cfg_err"}, 256'(cfg_err), 256'(0));
    endtask

    // Streams nrows*NB beats (optionally with random gaps) and checks every write slot.
    task automatic stream(input int base, input int nrows, input bit stall);
        int total;
        int k;
        int writes;
        int guard;
        logic [DW-1:0] d;
        logic [NB-1:0] exp_we;
        total  = nrows * int'(NB);
        k      = 0;
        writes = 0;
        guard  = 0;
        while (k < total && guard < 4000) begin
            guard++;
            s_if.s_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            d = DW'(k);
            s_if.s_data = d;
            tick();
            if (w_we != '0) writes++;
            if (s_if.s_valid) begin
                exp_we = NB'(1) << (k % int'(NB));
                chk("w_we", 256'(w_we), 256'(exp_we));
                chk("w_addr_wr", 256'(w_addr_wr), 256'(base + k / int'(NB)));
                chk("w_din_flat", 256'(w_din_flat), 256'({NB{d}}));
                k++;
                chk("rd_start", 256'(rd_start), 256'(k == total));
            end else begin
                chk("w_we gap", 256'(w_we), 256'(0));
                chk("rd_start gap", 256'(rd_start), 256'(0));
            end
        end
        s_if.s_valid = 1'b0;
        chk("beats", 256'(k), 256'(total));
        chk("writes", 256'(writes), 256'(total));
        chk("rd_addr_start", 256'(rd_addr_start), 256'(base));
        chk("rd_addr_end", 256'(rd_addr_end), 256'(base + nrows - 1));
        chk("s_ready kick", 256'(s_if.s_ready), 256'(0));
    endtask

    // Called in the KICK cycle; answers rd_done after a delay and checks load_done timing.
    task automatic handshake(input int delay);
        tick();
        chk("rd_start one cycle", 256'(rd_start), 256'(0));
        chk("w_we after last", 256'(w_we), 256'(0));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("busy wait", 256'(busy), 256'(1));
            chk("load_done early", 256'(load_done), 256'(0));
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("load_done", 256'(load_done), 256'(1));
        chk("busy done", 256'(busy), 256'(1));
        tick();
        chk("load_done pulse", 256'(load_done), 256'(0));
        chk("busy idle", 256'(busy), 256'(0));
    endtask

    task automatic start_load(input int base, input int nrows);
        base_addr  = AW'(base);
        num_rows   = (AW + 1)'(nrows);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle s_ready", 256'(s_if.s_ready), 256'(0));

        // First 1-row load; rd_done raised in KICK must wait for WAIT_RD.
        start_load(0, 1);
        chk("load1 s_ready", 256'(s_if.s_ready), 256'(1));
        chk("load1 busy", 256'(busy), 256'(1));
        stream(0, 1, 1'b0);
        rd_done = 1'b1;
        tick();
        chk("rd_done in kick ignored", 256'(load_done), 256'(0));
        tick();
        rd_done = 1'b0;
        chk("load1 load_done", 256'(load_done), 256'(1));
        tick();
        chk("load1 busy idle", 256'(busy), 256'(0));

        // Second 1-row load.
        start_load(0, 1);
        stream(0, 1, 1'b0);
        handshake(0);

        // Random-stall 3-row load.
        start_load(100, 3);
        stream(100, 3, 1'b1);
        handshake(2);

        // Config rejects.
        start_load(0, 0);
        chk("rows0 cfg_err", 256'(cfg_err), 256'(1));
        chk("rows0 s_ready", 256'(s_if.s_ready), 256'(0));
        chk("rows0 busy", 256'(busy), 256'(0));
        tick();
        chk("rows0 cfg_err pulse", 256'(cfg_err), 256'(0));
        chk("rows0 s_ready later", 256'(s_if.s_ready), 256'(0));
        start_load(500, 13);
        chk("overflow cfg_err", 256'(cfg_err), 256'(1));
        chk("overflow s_ready", 256'(s_if.s_ready), 256'(0));
        tick();
        chk("overflow cfg_err pulse", 256'(cfg_err), 256'(0));

        // Edge-of-bank load, then a slow read counter with a stray load_start.
        start_load(500, 12);
        chk("edge cfg_err", 256'(cfg_err), 256'(0));
        chk("edge s_ready", 256'(s_if.s_ready), 256'(1));
        stream(500, 12, 1'b0);
        tick();
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                base_addr  = '0;
                num_rows   = (AW + 1)'(1);
                load_start = 1'b1;
            end
            tick();
            load_start = 1'b0;
            chk("slow busy", 256'(busy), 256'(1));
            chk("slow s_ready", 256'(s_if.s_ready), 256'(0));
            chk("slow load_done", 256'(load_done), 256'(0));
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("slow load_done", 256'(load_done), 256'(1));
        tick();
        chk("slow load_done pulse", 256'(load_done), 256'(0));
        chk("slow busy idle", 256'(busy), 256'(0));
        tick();
        chk("no queued load", 256'(s_if.s_ready), 256'(0));

        // Reset in the middle of a load.
        start_load(0, 1);
        for (int k = 0; k < 7; k++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = DW'(k);
            tick();
        end
        chk("pre-reset w_we", 256'(w_we), 256'(NB'(1) << 6));
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        s_if.s_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-reset rd_start", 256'(rd_start), 256'(0));
            chk("post-reset w_we", 256'(w_we), 256'(0));
            chk("post-reset busy", 256'(busy), 256'(0));
        end
        start_load(0, 2);
        stream(0, 2, 1'b0);
        handshake(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
